// File: rtl/tx_drain_pkg.sv
// rtl/tx_drain_pkg.sv - shared state type, framing constants and PID helper for tx_drain_ctrl
// TX_DRAIN_CRC16_EN adds the CRC_LO/CRC_HI states to state_t.
package tx_drain_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_EOP
`ifdef TX_DRAIN_CRC16_EN
    ,
    S_CRC_LO,
    S_CRC_HI
`endif
  } state_t;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/tx_drain_ctrl_if.sv
// rtl/tx_drain_ctrl_if.sv - request, buffer-read and serializer signals of tx_drain_ctrl
// master is the controller side, slave is the surrounding buffer/serializer/requester.
interface tx_drain_ctrl_if #(
  parameter int LEN_W = 7
);
  logic             tx_start;
  logic [3:0]       tx_pid;
  logic [LEN_W-1:0] tx_len;
  logic             buf_empty;
  logic [7:0]       buf_rdata;
  logic             buf_r_enable;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ack;
  logic             eop;
  logic             busy;
  logic             underrun;

  modport master (
    input  tx_start, tx_pid, tx_len, buf_empty, buf_rdata, byte_ack,
    output buf_r_enable, byte_out, byte_valid, eop, busy, underrun
  );

  modport slave (
    output tx_start, tx_pid, tx_len, buf_empty, buf_rdata, byte_ack,
    input  buf_r_enable, byte_out, byte_valid, eop, busy, underrun
  );
endinterface

// File: rtl/tx_drain_ctrl_crc16.sv
// rtl/tx_drain_ctrl_crc16.sv - combinational CRC16 update for one byte, reflected, LSB first
// Built only when TX_DRAIN_CRC16_EN is defined.
`ifdef TX_DRAIN_CRC16_EN
module crc16_byte
  import tx_drain_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] poly_rev;
  logic [15:0] crc;

  always_comb begin
    poly_rev = '0;
    for (int i = 0; i < 16; i++) begin
      poly_rev[i] = CRC16_POLY[15-i];
    end
    crc = crc_i ^ {8'h00, data_i};
    for (int b = 0; b < 8; b++) begin
      crc = crc[0] ? ((crc >> 1) ^ poly_rev) : (crc >> 1);
    end
    crc_o = crc;
  end
endmodule
`endif

// File: rtl/tx_drain_ctrl.sv
// rtl/tx_drain_ctrl.sv - frames SYNC, PID, buffered payload and EOP for the byte serializer
// Define TX_DRAIN_CRC16_EN to append an inverted CRC16 (low byte first) after the payload.
module tx_drain_ctrl
  import tx_drain_pkg::*;
#(
  parameter int LEN_W            = 7,
  parameter int MAX_PKT          = 64,
  parameter int UNDERRUN_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  tx_drain_ctrl_if.master bus
);
  localparam int                WAIT_W   = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_PKT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(UNDERRUN_TIMEOUT);
`ifdef TX_DRAIN_CRC16_EN
  localparam state_t AFTER_DATA = S_CRC_LO;
`else
  localparam state_t AFTER_DATA = S_EOP;
`endif

  state_t            state_q, state_d;
  logic [3:0]        pid_q, pid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              underrun_q, underrun_d;
  logic              byte_valid;
  logic [7:0]        byte_out;
  logic              pop;
  logic              eop;

`ifdef TX_DRAIN_CRC16_EN
  logic [15:0] crc_q, crc_d, crc_next;

  crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (bus.buf_rdata),
    .crc_o  (crc_next)
  );
`endif

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wait_d     = '0;
    underrun_d = underrun_q;
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    pop        = 1'b0;
    eop        = 1'b0;
`ifdef TX_DRAIN_CRC16_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          pid_d   = bus.tx_pid;
          len_d   = (bus.tx_len > MAX_LEN) ? MAX_LEN : bus.tx_len;
          cnt_d   = '0;
`ifdef TX_DRAIN_CRC16_EN
          crc_d   = CRC16_INIT;
`endif
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        byte_valid = 1'b1;
        byte_out   = SYNC_BYTE;
        if (bus.byte_ack) state_d = S_PID;
      end
      S_PID: begin
        byte_valid = 1'b1;
        byte_out   = pid_byte(pid_q);
        if (bus.byte_ack) state_d = (len_q == '0) ? AFTER_DATA : S_DATA;
      end
      S_DATA: begin
        if (!bus.buf_empty) begin
          byte_valid = 1'b1;
          byte_out   = bus.buf_rdata;
          // Pop in the transfer cycle: the FWFT head advances exactly when the serializer takes it.
          if (bus.byte_ack) begin
            pop   = 1'b1;
            cnt_d = cnt_q + 1'b1;
`ifdef TX_DRAIN_CRC16_EN
            crc_d = crc_next;
`endif
            if (cnt_q == len_q - 1'b1) state_d = AFTER_DATA;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_MAX) begin
            underrun_d = 1'b1;
            state_d    = S_EOP;
          end
        end
      end
`ifdef TX_DRAIN_CRC16_EN
      S_CRC_LO: begin
        byte_valid = 1'b1;
        byte_out   = ~crc_q[7:0];
        if (bus.byte_ack) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        byte_valid = 1'b1;
        byte_out   = ~crc_q[15:8];
        if (bus.byte_ack) state_d = S_EOP;
      end
`endif
      S_EOP: begin
        eop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      underrun_q <= 1'b0;
`ifdef TX_DRAIN_CRC16_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      underrun_q <= underrun_d;
`ifdef TX_DRAIN_CRC16_EN
      crc_q      <= crc_d;
`endif
    end
  end

  // The buffer would otherwise pop on the same edge that resets the framer.
  assign bus.buf_r_enable = pop && !rst;
  assign bus.byte_valid   = byte_valid;
  assign bus.byte_out     = byte_out;
  assign bus.eop          = eop;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_tx_drain_ctrl.sv
// tb/tb_tx_drain_ctrl.sv - self-checking bench for tx_drain_ctrl with a packet-level reference model
module tb_tx_drain_ctrl;
  localparam int LEN_W   = 7;
  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 16;
`ifdef TX_DRAIN_CRC16_EN
  localparam int CRC_X = 2;
`else
  localparam int CRC_X = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  tx_drain_ctrl_if #(.LEN_W(LEN_W)) bus ();

  tx_drain_ctrl #(
    .LEN_W            (LEN_W),
    .MAX_PKT          (MAX_PKT),
    .UNDERRUN_TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] fifo[$];
  logic [7:0] exp_b[$];
  bit         exp_p[$];
  logic [7:0] rx_q[$];
  logic [7:0] want_q[$];
  bit         m_busy = 0, m_eop = 0, m_underrun = 0;
  int         m_wait = 0;
  int         pop_cnt = 0, busy_cnt = 0, eop_cnt = 0, hold = 0, stall = 0;
  bit         ack_idle = 0, pop_pend = 0, prev_stall = 0;
  logic [7:0] prev_out = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

`ifdef TX_DRAIN_CRC16_EN
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
`endif

  // Expected byte stream of the packet, derived from the buffer contents at start time.
  task automatic build();
    int         lenc;
    logic [7:0] v;
    logic [15:0] crc;
    lenc = (int'(bus.tx_len) > MAX_PKT) ? MAX_PKT : int'(bus.tx_len);
    exp_b.delete(); exp_p.delete();
    exp_b.push_back(8'h80);                      exp_p.push_back(1'b0);
    exp_b.push_back({~bus.tx_pid, bus.tx_pid});  exp_p.push_back(1'b0);
    crc = 16'hFFFF;
    for (int i = 0; i < lenc; i++) begin
      v = (i < fifo.size()) ? fifo[i] : 8'h00;
      exp_b.push_back(v); exp_p.push_back(1'b1);
`ifdef TX_DRAIN_CRC16_EN
      crc = crc_upd(crc, v);
`endif
    end
`ifdef TX_DRAIN_CRC16_EN
    exp_b.push_back(~crc[7:0]);  exp_p.push_back(1'b0);
    exp_b.push_back(~crc[15:8]); exp_p.push_back(1'b0);
`else
    crc = ~crc;
`endif
  endtask

  always @(negedge clk) begin
    bit head_pay, buf_dry, want_valid, xfer;
    if (rst) begin
      chk("rst_no_pop", bus.buf_r_enable, 1'b0);
      m_busy = 0; m_eop = 0; m_wait = 0; m_underrun = 0;
      exp_b.delete(); exp_p.delete();
      pop_pend = 0; prev_stall = 0; hold = 0;
    end else begin
      head_pay   = (exp_p.size() > 0) && exp_p[0];
      buf_dry    = (fifo.size() == 0);
      want_valid = m_busy && !m_eop && (exp_b.size() > 0) && !(head_pay && buf_dry);
      chk("busy", bus.busy, m_busy);
      chk("eop", bus.eop, m_eop);
      chk("byte_valid", bus.byte_valid, want_valid);
      chk("underrun", bus.underrun, m_underrun);
      if (want_valid) chk("byte_out", bus.byte_out, exp_b[0]);
      chk("r_enable", bus.buf_r_enable, want_valid && bus.byte_ack && head_pay);
      if (prev_stall) chk("stall_hold", bus.byte_out, prev_out);
      xfer       = want_valid && bus.byte_ack;
      prev_stall = bus.byte_valid && !bus.byte_ack;
      prev_out   = bus.byte_out;
      hold       = prev_stall ? hold + 1 : 0;
      pop_pend   = bus.buf_r_enable;
      if (bus.busy) busy_cnt++;
      if (bus.buf_r_enable) pop_cnt++;
      if (bus.eop) eop_cnt++;
      if (bus.byte_valid && bus.byte_ack) rx_q.push_back(bus.byte_out);
      if (m_eop) begin
        m_eop = 0; m_busy = 0;
      end else if (m_busy) begin
        if (xfer) begin
          void'(exp_b.pop_front()); void'(exp_p.pop_front());
          if (exp_b.size() == 0) m_eop = 1;
        end
        if (head_pay && buf_dry) begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_eop = 1; m_underrun = 1;
            exp_b.delete(); exp_p.delete();
          end
        end else begin
          m_wait = 0;
        end
      end else if (bus.tx_start) begin
        build();
        m_busy = 1;
      end
    end
  end

  task automatic drive_buf();
    bus.buf_empty = (fifo.size() == 0);
    bus.buf_rdata = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    pop_pend = 0;
    drive_buf();
    #1;
    bus.byte_ack = bus.byte_valid ? (hold >= stall) : ack_idle;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    fifo.delete();
    for (int i = 0; i < n; i++) fifo.push_back(base + 8'(i));
    drive_buf();
  endtask

  task automatic run_pkt(input logic [3:0] pid, input logic [6:0] len, input int stl, input int mid_start);
    int n;
    rx_q.delete(); pop_cnt = 0; busy_cnt = 0; eop_cnt = 0; stall = stl;
    bus.tx_pid = pid; bus.tx_len = len; bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    n = 0;
    while (eop_cnt == 0 && n < 400) begin
      step();
      n++;
      if (n == mid_start) begin
        bus.tx_start = 1'b1; bus.tx_pid = 4'hF; bus.tx_len = 7'd5;
      end else begin
        bus.tx_start = 1'b0;
      end
    end
    step();
    chk("pkt_timeout", n < 400, 1'b1);
  endtask

  task automatic cmp_stream(input string name, input int n_extra);
    chk({name, "_len"}, rx_q.size(), want_q.size() + n_extra);
    for (int i = 0; i < want_q.size(); i++)
      chk({name, "_byte"}, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, want_q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.tx_start = 1'b0; bus.tx_pid = 4'h0; bus.tx_len = '0; bus.byte_ack = 1'b0;
    fifo.delete(); drive_buf();
    rst = 1'b1;
    step(); step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.byte_valid, 1'b0);
    chk("rst_eop", bus.eop, 1'b0);
    chk("rst_underrun", bus.underrun, 1'b0);
    chk("rst_pop", bus.buf_r_enable, 1'b0);
    rst = 1'b0;
    step();

    // Nominal packet, ack always high
    load(4, 8'h01);
    run_pkt(4'h3, 7'd4, 0, -1);
    want_q = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
    cmp_stream("s1", CRC_X);
    chk("s1_pops", pop_cnt, 4);
    chk("s1_busy", busy_cnt, 7 + CRC_X);
    chk("s1_eops", eop_cnt, 1);
    chk("s1_underrun", bus.underrun, 1'b0);

    // Zero-length packet
    load(0, 8'h00);
    run_pkt(4'h5, 7'd0, 0, -1);
    want_q = '{8'h80, 8'hA5};
`ifdef TX_DRAIN_CRC16_EN
    want_q.push_back(8'h00); want_q.push_back(8'h00);
`endif
    cmp_stream("s2", 0);
    chk("s2_pops", pop_cnt, 0);
    chk("s2_busy", busy_cnt, 3 + CRC_X);

    // Serializer stalls three cycles on every byte
    load(4, 8'h01);
    run_pkt(4'h3, 7'd4, 3, -1);
    want_q = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
    cmp_stream("s3", CRC_X);
    chk("s3_pops", pop_cnt, 4);
    chk("s3_busy", busy_cnt, 25 + 4 * CRC_X);

    // Underrun: 2 of 4 bytes available, ack raised while nothing is offered
    load(2, 8'h11);
    ack_idle = 1'b1;
    run_pkt(4'h9, 7'd4, 0, -1);
    want_q = '{8'h80, 8'h69, 8'h11, 8'h12};
    cmp_stream("s4", 0);
    chk("s4_pops", pop_cnt, 2);
    chk("s4_busy", busy_cnt, 21);
    chk("s4_underrun", bus.underrun, 1'b1);
    ack_idle = 1'b0;
    load(3, 8'h21);
    run_pkt(4'h1, 7'd3, 0, -1);
    want_q = '{8'h80, 8'hE1, 8'h21, 8'h22, 8'h23};
    cmp_stream("s4b", CRC_X);
    chk("s4b_sticky", bus.underrun, 1'b1);
    do_reset();
    chk("s4_cleared", bus.underrun, 1'b0);

    // Reset in DATA after two payload bytes
    load(4, 8'h31);
    stall = 0;
    bus.tx_pid = 4'h2; bus.tx_len = 7'd4; bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("s5_mid_fifo", fifo.size(), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_busy", bus.busy, 1'b0);
    chk("s5_valid", bus.byte_valid, 1'b0);
    chk("s5_byte", bus.byte_out, 8'h00);
    chk("s5_pop", bus.buf_r_enable, 1'b0);
    chk("s5_fifo", fifo.size(), 2);
    load(4, 8'h41);
    run_pkt(4'h7, 7'd4, 0, -1);
    want_q = '{8'h80, 8'h87, 8'h41, 8'h42, 8'h43, 8'h44};
    cmp_stream("s5", CRC_X);
    chk("s5_pops", pop_cnt, 4);

    // Oversized length clamps to MAX_PKT; mid-packet start is ignored
    load(70, 8'h00);
    run_pkt(4'hA, 7'd100, 0, 20);
    chk("s6_pops", pop_cnt, 64);
    chk("s6_left", fifo.size(), 6);
    chk("s6_len", rx_q.size(), 66 + CRC_X);
    chk("s6_last", (rx_q.size() > 65) ? 32'(rx_q[65]) : 32'hFFFF_FFFF, 8'h3F);
    chk("s6_busy", busy_cnt, 67 + CRC_X);
    chk("s6_eops", eop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_drain_ctrl.md
Name: tx_drain_ctrl

Overview:
Read-side packet sequencer for the output buffer FIFO. On a start request it frames one packet for the downstream byte serializer: SYNC byte, PID byte, then tx_len payload bytes popped from the buffer, then an EOP pulse. It runs in the buffer's read clock domain and is the only block that drives the buffer's r_enable.

Parameters:
LEN_W, 7, width of tx_len; payload is capped at MAX_PKT.
MAX_PKT, 64, maximum payload bytes per packet; larger tx_len values are clamped to this.
SYNC_BYTE, 8'h80, first byte of every packet.
UNDERRUN_TIMEOUT, 16, consecutive empty-buffer cycles allowed mid-payload before the packet is aborted.

Ports:
clk  in  1  single clock, rising edge; same as the buffer read clock.
rst  in  1  synchronous, active-high reset.
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE.
tx_pid  in  4  PID, captured on an accepted tx_start.
tx_len  in  LEN_W  payload byte count, captured on an accepted tx_start.
buf_empty  in  1  buffer empty flag.
buf_rdata  in  8  buffer head byte (first-word fall-through), valid while !buf_empty.
buf_r_enable  out  1  one-cycle pop of the buffer head.
byte_out  out  8  byte offered to the serializer.
byte_valid  out  1  byte_out is valid.
byte_ack  in  1  serializer accepts byte_out this cycle.
eop  out  1  one-cycle end-of-packet pulse.
busy  out  1  high in every state except IDLE.
underrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst high at a clk edge, in any state, including mid-packet): state returns to IDLE; all outputs go to 0; latched len, pid, counters and underrun are cleared. No buffer pop occurs in the reset cycle.
- States: IDLE, SYNC, PID, DATA, EOP.
- IDLE:
  - tx_start=1 latches pid and len = min(tx_len, MAX_PKT), clears cnt, and moves to SYNC on the next cycle.
  - tx_start while busy is ignored; no queuing.
- Handshake: a transfer occurs on a cycle with byte_valid && byte_ack. byte_out must stay stable while byte_valid=1 and byte_ack=0. byte_ack while byte_valid=0 is ignored.
- SYNC: byte_valid=1, byte_out=SYNC_BYTE; on transfer go to PID.
- PID: byte_out = {~pid, pid}; on transfer go to DATA, or straight to EOP if len==0.
- DATA:
  - byte_valid = !buf_empty and byte_out = buf_rdata.
  - buf_r_enable = byte_valid && byte_ack, so the pop happens in the same cycle as the transfer; never pop while buf_empty.
  - Each transfer increments cnt; the transfer with cnt==len-1 moves to EOP.
  - Buffer empty: byte_valid=0 and wait_cnt increments. wait_cnt clears whenever buf_empty is low.
  - wait_cnt reaching UNDERRUN_TIMEOUT sets underrun and moves to EOP (packet truncated). Remaining bytes stay in the buffer.
- EOP: eop=1 and byte_valid=0 for exactly one cycle, then IDLE. busy drops the cycle after eop.
- Minimum packet latency with byte_ack tied high and a non-empty buffer: start -> SYNC in 1 cycle, then one cycle per byte, then 1 EOP cycle.
- cnt is LEN_W bits wide and never wraps, because len <= MAX_PKT < 2^LEN_W.

Optional Feature:
- Macro TX_DRAIN_CRC16_EN.
  - Defined: adds states CRC_LO and CRC_HI between DATA and EOP. A running CRC16 (poly 0x8005, init 0xFFFF, LSB-first reflected, result inverted) is updated on every DATA transfer. The low byte is sent first. len==0 goes PID -> CRC_LO. An underrun abort skips the CRC states.
  - Undefined: no CRC states or logic; DATA goes straight to EOP.

Decomposition:
- Package tx_drain_pkg holds: the state enum (state_t); SYNC_BYTE, CRC16_POLY and CRC16_INIT constants; a pid_byte function returning {~pid, pid}.
- One sub-module, crc16_byte: a combinational next-CRC for one byte, instantiated only under TX_DRAIN_CRC16_EN.

Test Plan:
- Buffer preloaded with 8'h01..8'h04, tx_pid=4'h3, tx_len=4, byte_ack=1 -> byte stream 80, C3, 01, 02, 03, 04; four buf_r_enable pulses; eop one cycle later; busy for 7 cycles; underrun=0.
- tx_len=0, tx_pid=4'h5 -> bytes 80, A5, eop; buf_r_enable never asserted. With TX_DRAIN_CRC16_EN: 80, A5, 00, 00, eop.
- Same as scenario 1 but byte_ack held low for 3 cycles on each byte -> byte_out stable while stalled; exactly one pop per byte; identical byte sequence.
- tx_len=4 with 2 bytes in the buffer and no refill -> two bytes sent; after 16 empty cycles underrun=1 and eop pulses; next packet still runs and underrun stays 1 until rst.
- rst asserted during DATA with 2 of 4 bytes sent -> next cycle IDLE, all outputs 0, no extra pop; a new tx_start then sends a full packet starting with 80.
- tx_len=100 (MAX_PKT=64) -> exactly 64 payload pops; a tx_start pulsed mid-packet is ignored.
